// File: rtl/btn_evt_pkg.sv
// Shared types for the front-panel button event path: event kinds, hold states, kind width.
package btn_evt_pkg;

  localparam int unsigned KIND_W = 2;

  typedef enum logic [KIND_W-1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_RELEASE = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_kind_t;

  typedef enum logic [1:0] {
    RELEASED,
    HELD_WAIT,
    REPEATING
  } hold_state_t;

endpackage

// File: rtl/btn_channel.sv
// One button lane: 2-FF synchroniser, tick-based integrator, optional hold FSM
// (AUTOREPEAT_EN) and a single-entry pending event slot.
module btn_channel
  import btn_evt_pkg::*;
#(
  parameter int unsigned STABLE_TICKS       = 4
`ifdef AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY_TICKS = 200,
  parameter int unsigned REPEAT_RATE_TICKS  = 40
`endif
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      btn_raw,
  input  logic      tick,
  input  logic      grant,
  output logic      level,
  output logic      pend,
  output evt_kind_t pend_kind,
  output logic      drop
);

  localparam int unsigned CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  evt_kind_t        kind_q, kind_d;
  logic             flip;
  logic             post;
  evt_kind_t        post_kind;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    if (tick) begin
      if (s2_q != level_q) begin
        if (cnt_q == CNT_W'(STABLE_TICKS - 1)) begin
          flip    = 1'b1;
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                                    REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int unsigned RCNT_W  = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  hold_state_t       state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              rpt;

  // A level flip on this tick takes priority over any repeat due on the same tick.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt     = 1'b0;
    if (flip) begin
      state_d = level_q ? RELEASED : HELD_WAIT;
      rcnt_d  = '0;
    end else if (tick) begin
      case (state_q)
        HELD_WAIT: begin
          if (rcnt_q == RCNT_W'(REPEAT_DELAY_TICKS - 1)) begin
            state_d = REPEATING;
            rcnt_d  = '0;
            rpt     = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        REPEATING: begin
          if (rcnt_q == RCNT_W'(REPEAT_RATE_TICKS - 1)) begin
            rcnt_d = '0;
            rpt    = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: rcnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end
`endif

  always_comb begin
    post      = flip;
    post_kind = level_q ? EVT_RELEASE : EVT_PRESS;
`ifdef AUTOREPEAT_EN
    if (!flip && rpt) begin
      post      = 1'b1;
      post_kind = EVT_REPEAT;
    end
`endif
  end

  // A grant in the same cycle ships the old entry, so the new post is not a drop.
  always_comb begin
    pend_d = pend_q;
    kind_d = kind_q;
    drop   = 1'b0;
    if (grant) pend_d = 1'b0;
    if (post) begin
      pend_d = 1'b1;
      kind_d = post_kind;
      drop   = pend_q && !grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      kind_q  <= EVT_NONE;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      kind_q  <= kind_d;
    end
  end

  assign level     = level_q;
  assign pend      = pend_q;
  assign pend_kind = kind_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Front-panel debounce and event scheduler: shared tick, N button lanes, round-robin
// serialisation onto a valid/ready stream. Auto-repeat is built when AUTOREPEAT_EN is defined.
module button_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int unsigned N_BTN              = 5,
  parameter int unsigned TICK_DIV           = 250000,
  parameter int unsigned STABLE_TICKS       = 4,
  parameter int unsigned REPEAT_DELAY_TICKS = 200,
  parameter int unsigned REPEAT_RATE_TICKS  = 40,
  localparam int unsigned IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn_in,
  output logic [N_BTN-1:0]  btn_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [IDW-1:0]    evt_id,
  output logic [KIND_W-1:0] evt_kind,
  output logic [7:0]        evt_drop_cnt
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             tick;
  logic [N_BTN-1:0] pend, drop, grant;
  evt_kind_t        pend_kind [N_BTN];

  logic             valid_q, valid_d;
  logic [IDW-1:0]   id_q, id_d;
  evt_kind_t        kind_q, kind_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [7:0]       drop_q, drop_d;

  assign tick   = (tcnt_q == TW'(TICK_DIV - 1));
  assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_channel #(
      .STABLE_TICKS       (STABLE_TICKS)
`ifdef AUTOREPEAT_EN
      ,
      .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
      .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
`endif
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_in[g]),
      .tick      (tick),
      .grant     (grant[g]),
      .level     (btn_level[g]),
      .pend      (pend[g]),
      .pend_kind (pend_kind[g]),
      .drop      (drop[g])
    );
  end

  // Search starts one past the last grant so every lane gets a turn.
  always_comb begin
    logic           found;
    logic [IDW-1:0] sel;
    int unsigned    idx;
    int unsigned    nd;
    int unsigned    tot;
    found   = 1'b0;
    sel     = '0;
    idx     = 0;
    nd      = 0;
    tot     = 0;
    grant   = '0;
    valid_d = valid_q;
    id_d    = id_q;
    kind_d  = kind_q;
    ptr_d   = ptr_q;
    for (int unsigned i = 1; i <= N_BTN; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
    if (!valid_q || evt_ready) begin
      if (found) begin
        grant[sel] = 1'b1;
        valid_d    = 1'b1;
        id_d       = sel;
        kind_d     = pend_kind[sel];
        ptr_d      = sel;
      end else begin
        valid_d = 1'b0;
      end
    end
    for (int unsigned i = 0; i < N_BTN; i++) nd = nd + 32'(drop[i]);
    tot    = 32'(drop_q) + nd;
    drop_d = (tot > 255) ? 8'hFF : 8'(tot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      kind_q  <= EVT_NONE;
      ptr_q   <= IDW'(N_BTN - 1);
      drop_q  <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      kind_q  <= kind_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
    end
  end

  assign evt_valid    = valid_q;
  assign evt_id       = id_q;
  assign evt_kind     = kind_q;
  assign evt_drop_cnt = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with a small configuration (3 buttons, 4-clk tick).
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_in = '0;
  logic       evt_ready = 1'b0;
  logic [2:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [1:0] evt_kind;
  logic [7:0] evt_drop_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0] id;
    logic [1:0] kind;
    int         t;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    logic [2:0] btn;
    logic [2:0] lvl;
    int         n;
    logic [5:0] ids;
    logic [5:0] kinds;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN              (3),
    .TICK_DIV           (4),
    .STABLE_TICKS       (3),
    .REPEAT_DELAY_TICKS (5),
    .REPEAT_RATE_TICKS  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .evt_kind     (evt_kind),
    .evt_drop_cnt (evt_drop_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (rst_n && evt_valid && evt_ready) begin
      e.id   = evt_id;
      e.kind = evt_kind;
      e.t    = cyc;
      evq.push_back(e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_level(input logic [2:0] exp, output int n);
    n = 0;
    while (btn_level != exp && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic chk_last_kind(input string name, input int exp);
    if (evq.size() == 0) chk(name, -1, exp);
    else chk(name, evq[evq.size()-1].kind, exp);
  endtask

  initial begin
    int n;
    int sz;

    tbl[0] = '{3'b111, 3'b111, 3, {2'd2, 2'd1, 2'd0}, {2'd1, 2'd1, 2'd1}};
    tbl[1] = '{3'b000, 3'b000, 3, {2'd2, 2'd1, 2'd0}, {2'd2, 2'd2, 2'd2}};
    tbl[2] = '{3'b101, 3'b101, 2, {2'd0, 2'd2, 2'd0}, {2'd0, 2'd1, 2'd1}};
    tbl[3] = '{3'b000, 3'b000, 2, {2'd0, 2'd2, 2'd0}, {2'd0, 2'd2, 2'd2}};
    tbl[4] = '{3'b010, 3'b010, 1, {2'd0, 2'd0, 2'd1}, {2'd0, 2'd0, 2'd1}};
    tbl[5] = '{3'b000, 3'b000, 1, {2'd0, 2'd0, 2'd1}, {2'd0, 2'd0, 2'd2}};
    tbl[6] = '{3'b111, 3'b111, 3, {2'd1, 2'd0, 2'd2}, {2'd1, 2'd1, 2'd1}};
    tbl[7] = '{3'b000, 3'b000, 3, {2'd1, 2'd0, 2'd2}, {2'd2, 2'd2, 2'd2}};

    step(3);
    chk("rst_level", btn_level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_kind", evt_kind, 0);
    chk("rst_drop", evt_drop_cnt, 0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step(1);

    for (int v = 0; v < 8; v++) begin
      evq.delete();
      btn_in = tbl[v].btn;
      wait_level(tbl[v].lvl, n);
      chk($sformatf("v%0d_level", v), btn_level, tbl[v].lvl);
      checks++;
      if (n < 11 || n > 14) begin
        failures++;
        $display("FAIL v%0d_latency actual=%0d required=11..14", v, n);
      end
      step(5);
      chk($sformatf("v%0d_nevt", v), evq.size(), tbl[v].n);
      for (int k = 0; k < tbl[v].n && k < evq.size(); k++) begin
        chk($sformatf("v%0d_id%0d", v, k), evq[k].id, tbl[v].ids[2*k +: 2]);
        chk($sformatf("v%0d_kind%0d", v, k), evq[k].kind, tbl[v].kinds[2*k +: 2]);
      end
      chk($sformatf("v%0d_idle", v), evt_valid, 0);
    end
    chk("tbl_drop", evt_drop_cnt, 0);

    evq.delete();
    for (int k = 0; k < 8; k++) begin
      btn_in[0] = (k % 2 == 0);
      step(5);
    end
    btn_in = '0;
    step(30);
    chk("bounce_level", btn_level, 0);
    chk("bounce_nevt", evq.size(), 0);
    chk("bounce_drop", evt_drop_cnt, 0);

    evq.delete();
    btn_in = 3'b100;
`ifdef AUTOREPEAT_EN
    n = 0;
    while (evq.size() < 4 && n < 200) begin
      step();
      n++;
    end
    chk("rpt_nevt", evq.size(), 4);
    if (evq.size() >= 4) begin
      chk("rpt_id", evq[3].id, 2);
      chk("rpt_kind0", evq[0].kind, 1);
      chk("rpt_kind1", evq[1].kind, 3);
      chk("rpt_kind3", evq[3].kind, 3);
      chk("rpt_delay", evq[1].t - evq[0].t, 20);
      chk("rpt_rate1", evq[2].t - evq[1].t, 8);
      chk("rpt_rate2", evq[3].t - evq[2].t, 8);
    end
`else
    step(80);
    chk("hold_nevt", evq.size(), 1);
    if (evq.size() >= 1) chk("hold_kind", evq[0].kind, 1);
`endif
    btn_in = '0;
    wait_level(3'b000, n);
    step(5);
    chk("rel_level", btn_level, 0);
    chk_last_kind("rel_kind", 2);
    sz = evq.size();
    step(40);
    chk("rel_quiet", evq.size(), sz);

    evq.delete();
    evt_ready = 1'b0;
    btn_in = 3'b001;
    wait_level(3'b001, n);
    step(2);
    chk("bp_valid1", evt_valid, 1);
    chk("bp_id1", evt_id, 0);
    chk("bp_kind1", evt_kind, 1);
    btn_in = 3'b000;
    wait_level(3'b000, n);
    step(2);
    chk("bp_valid2", evt_valid, 1);
    chk("bp_kind2", evt_kind, 1);
    chk("bp_drop0", evt_drop_cnt, 0);
    btn_in = 3'b001;
    wait_level(3'b001, n);
    step(2);
    chk("bp_kind3", evt_kind, 1);
    chk("bp_drop1", evt_drop_cnt, 1);
    evt_ready = 1'b1;
    btn_in = 3'b000;
    wait_level(3'b000, n);
    step(5);
    chk("bp_nevt", evq.size(), 3);
    if (evq.size() >= 3) begin
      chk("bp_ev0", evq[0].kind, 1);
      chk("bp_ev1", evq[1].kind, 1);
      chk("bp_ev2", evq[2].kind, 2);
    end
    chk("bp_drop_end", evt_drop_cnt, 1);

    evq.delete();
    evt_ready = 1'b0;
    btn_in = 3'b010;
    wait_level(3'b010, n);
    step(2);
    chk("mr_valid_before", evt_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_level", btn_level, 0);
    chk("mr_valid", evt_valid, 0);
    chk("mr_id", evt_id, 0);
    chk("mr_kind", evt_kind, 0);
    chk("mr_drop", evt_drop_cnt, 0);
    step(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    evq.delete();
    wait_level(3'b010, n);
    chk("mr_requal_cycles", n, 12);
    step(3);
    chk("mr_nevt", evq.size(), 1);
    if (evq.size() >= 1) begin
      chk("mr_id_evt", evq[0].id, 1);
      chk("mr_kind_evt", evq[0].kind, 1);
    end
    btn_in = '0;
    wait_level(3'b000, n);
    step(5);
    chk_last_kind("mr_rel_kind", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
